// File: rtl/ram_port_pkg.sv
// ram_port_pkg: shared types and constants for the data RAM port initiator
package ram_port_pkg;
  localparam int RAM_DEPTH = 126;
  localparam int WORD_W = 16;
  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_PULSE, FIN} state_t;
endpackage

// File: rtl/ram_port_master.sv
// ram_port_master: streams a RAM block out (dump) or fills it from a stream (load) while the CPU is halted
module ram_port_master
  import ram_port_pkg::*;
#(
  parameter int DW = WORD_W,
  parameter int AW = 16,
  parameter int DEPTH = RAM_DEPTH,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready
);
  localparam int LW = $clog2(READ_LAT + 1);
  state_t state, state_n;
  logic [AW-1:0] rem, rem_n, addr_n;
  logic [LW-1:0] lat, lat_n;
  logic [DW-1:0] wdata_n, odata_n;
  logic we_n, ovalid_n, olast_n, iready_n, busy_n, done_n, err_n;
  logic [AW:0] end_addr;
  logic last;
  assign end_addr = {1'b0, base} + {1'b0, count};
  assign last = rem == AW'(1);
  always_comb begin
    state_n = state;
    rem_n = rem;
    addr_n = mem_addr;
    lat_n = lat;
    wdata_n = mem_wdata;
    odata_n = out_data;
    we_n = 1'b0;
    ovalid_n = out_valid;
    olast_n = out_last;
    iready_n = in_ready;
    busy_n = busy;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        busy_n = 1'b1;
        addr_n = base;
        rem_n = count;
        lat_n = '0;
        if (count == '0 || end_addr > (AW+1)'(DEPTH)) begin
          state_n = FIN;
          done_n = 1'b1;
          err_n = count != '0;
        end else if (mode == MODE_DUMP) begin
          state_n = RD_WAIT;
        end else begin
          state_n = WR_WAIT;
          iready_n = 1'b1;
        end
      end
      RD_WAIT: if (lat == LW'(READ_LAT)) begin
        odata_n = mem_rdata;
        ovalid_n = 1'b1;
        olast_n = last;
        state_n = RD_HOLD;
      end else begin
        lat_n = lat + 1'b1;
      end
      // out_valid is always high here, so out_ready alone completes the handshake
      RD_HOLD: if (out_ready) begin
        ovalid_n = 1'b0;
        olast_n = 1'b0;
        addr_n = mem_addr + 1'b1;
        rem_n = rem - 1'b1;
        lat_n = '0;
        state_n = last ? FIN : RD_WAIT;
        done_n = last;
      end
      WR_WAIT: if (in_valid) begin
        wdata_n = in_data;
        we_n = 1'b1;
        iready_n = 1'b0;
        state_n = WR_PULSE;
      end
      WR_PULSE: begin
        addr_n = mem_addr + 1'b1;
        rem_n = rem - 1'b1;
        iready_n = !last;
        state_n = last ? FIN : WR_WAIT;
        done_n = last;
      end
      FIN: begin
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      lat <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      lat <= lat_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      mem_we <= we_n;
      out_data <= odata_n;
      out_valid <= ovalid_n;
      out_last <= olast_n;
      in_ready <= iready_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: directed checks of dump/load, back-pressure, range limits, reset and busy-start
module tb_ram_port_master;
  logic clk, reset, start, mode, out_ready, in_valid;
  logic [15:0] base, count, in_data, rdata;
  logic busy, done, err, mem_we, out_valid, out_last, in_ready;
  logic [15:0] mem_addr, mem_wdata, out_data;
  logic pre_we;
  logic [6:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] ram [0:125];
  logic [15:0] we_addr [0:63];
  logic [15:0] we_data [0:63];
  logic [15:0] rx_data [0:63];
  logic rx_last [0:63];
  int we_cnt = 0;
  int rx_cnt = 0;
  int cmp = 0;
  int mis = 0;

  ram_port_master dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .count(count),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(rdata), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we && mem_addr < 16'd126) ram[mem_addr[6:0]] <= mem_wdata;
    rdata <= (mem_addr < 16'd126) ? ram[mem_addr[6:0]] : 16'h0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_addr[we_cnt] <= mem_addr;
      we_data[we_cnt] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (out_valid && out_ready) begin
      rx_data[rx_cnt] <= out_data;
      rx_last[rx_cnt] <= out_last;
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic m, input logic [15:0] b, input logic [15:0] c);
    start = 1'b1; mode = m; base = b; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    in_data = w; in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!mem_we && n < 50);
    in_valid = 1'b0;
    chk("send we", mem_we, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    chk({tag, " done"}, done, 1);
    chk({tag, " err"}, err, exp_err);
    @(negedge clk);
    chk({tag, " idle"}, {busy, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, r0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; base = '0; count = '0;
    out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
    pre_we = 1'b1; pre_addr = 7'd0; pre_data = 16'd32761;
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    chk("reset outputs", {busy, done, err, mem_we, out_valid, out_last, in_ready, mem_addr, mem_wdata, out_data}, 0);
    reset = 1'b0;
    @(negedge clk);

    // single-word dump of the square-root operand
    w0 = we_cnt;
    issue(1'b0, 16'd0, 16'd1);
    chk("d1 busy/addr", {busy, mem_addr}, {1'b1, 16'd0});
    @(negedge clk);
    chk("d1 not yet valid", out_valid, 0);
    @(negedge clk);
    chk("d1 beat", {out_valid, out_last, out_data}, {1'b1, 1'b1, 16'h7FF9});
    @(negedge clk);
    chk("d1 done", {done, err, out_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("d1 idle", {busy, done}, 0);
    chk("d1 no writes", we_cnt - w0, 0);

    // load 4, 9, 25 at 2..4
    w0 = we_cnt;
    issue(1'b1, 16'd2, 16'd3);
    chk("ld in_ready", in_ready, 1);
    send(16'd4); send(16'd9); send(16'd25);
    wait_done("ld", 1'b0);
    chk("ld writes", we_cnt - w0, 3);
    chk("ld w0", {we_addr[w0], we_data[w0]}, {16'd2, 16'd4});
    chk("ld w1", {we_addr[w0+1], we_data[w0+1]}, {16'd3, 16'd9});
    chk("ld w2", {we_addr[w0+2], we_data[w0+2]}, {16'd4, 16'd25});

    // read them back
    r0 = rx_cnt;
    issue(1'b0, 16'd2, 16'd3);
    wait_done("rb", 1'b0);
    chk("rb beats", rx_cnt - r0, 3);
    chk("rb 0", {rx_last[r0], rx_data[r0]}, {1'b0, 16'd4});
    chk("rb 1", {rx_last[r0+1], rx_data[r0+1]}, {1'b0, 16'd9});
    chk("rb 2", {rx_last[r0+2], rx_data[r0+2]}, {1'b1, 16'd25});

    // back-pressure mid-block
    r0 = rx_cnt;
    out_ready = 1'b0;
    issue(1'b0, 16'd2, 16'd3);
    wait_valid("bp v0");
    chk("bp d0", out_data, 16'd4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid("bp v1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold", {out_valid, out_data, mem_addr}, {1'b1, 16'd9, 16'd3});
    end
    out_ready = 1'b1;
    wait_done("bp", 1'b0);
    chk("bp beats", rx_cnt - r0, 3);
    chk("bp words", {rx_data[r0], rx_data[r0+1], rx_data[r0+2], rx_last[r0+2]}, {16'd4, 16'd9, 16'd25, 1'b1});

    // range boundaries
    w0 = we_cnt; r0 = rx_cnt;
    issue(1'b0, 16'd5, 16'd0);
    chk("zero done", {done, err}, {1'b1, 1'b0});
    @(negedge clk);
    chk("zero idle", {busy, done}, 0);
    issue(1'b1, 16'd120, 16'd7);
    chk("over done", {done, err, in_ready}, {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    chk("over idle", {busy, done, err}, 0);
    chk("no access", {we_cnt - w0, rx_cnt - r0}, 0);
    issue(1'b1, 16'd120, 16'd6);
    for (int i = 0; i < 6; i++) send(16'd100 + 16'(i));
    wait_done("edge", 1'b0);
    chk("edge writes", we_cnt - w0, 6);
    chk("edge last", {we_addr[w0+5], we_data[w0+5]}, {16'd125, 16'd105});

    // reset in WR_WAIT after two of four words
    w0 = we_cnt;
    issue(1'b1, 16'd10, 16'd4);
    send(16'h1111); send(16'h2222);
    @(negedge clk);
    chk("rst in WR_WAIT", in_ready, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst outputs", {busy, done, err, mem_we, out_valid, out_last, in_ready, mem_addr, mem_wdata, out_data}, 0);
    @(negedge clk);
    chk("rst writes", we_cnt - w0, 2);
    r0 = rx_cnt;
    issue(1'b0, 16'd10, 16'd2);
    chk("rst restart", busy, 1);
    wait_done("rst rb", 1'b0);
    chk("rst rb data", {rx_data[r0], rx_data[r0+1]}, {16'h1111, 16'h2222});

    // start while busy is ignored
    w0 = we_cnt; r0 = rx_cnt;
    issue(1'b0, 16'd2, 16'd3);
    issue(1'b1, 16'd50, 16'd1);
    wait_done("busy", 1'b0);
    chk("busy beats", rx_cnt - r0, 3);
    chk("busy words", {rx_data[r0], rx_data[r0+1], rx_data[r0+2]}, {16'd4, 16'd9, 16'd25});
    chk("busy no write", {we_cnt - w0, in_ready}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
